// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide engine with the architectural HI/LO registers.
// It computes one bit per cycle and raises a stall when the pipeline touches HI/LO or issues an op during an operation.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_write,
    input  logic             lo_write,
    input  logic [WIDTH-1:0] wdata,
    input  logic             hilo_read,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t state_r, state_s;

    logic               is_div_r;
    logic [WIDTH-1:0]   div_r;      // multiplicand for multiply, divisor for divide
    logic [WIDTH-1:0]   acc_hi_r;   // partial product high half / partial remainder
    logic [WIDTH-1:0]   acc_lo_r;   // multiplier bits / dividend bits becoming quotient
    logic               neg_q_r;
    logic               neg_r_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               done_r;

    logic               a_neg_s;
    logic               b_neg_s;
    logic               div0_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic               div_ge_s;
    logic [WIDTH-1:0]   div_diff_s;
    logic [WIDTH-1:0]   step_hi_s;
    logic [WIDTH-1:0]   step_lo_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   quo_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;
    logic [WIDTH-1:0]   res_hi_s;
    logic [WIDTH-1:0]   res_lo_s;

    // A zero divisor runs on the raw dividend with no sign flags, which yields quotient all-ones and remainder equal to a.
    assign a_neg_s = ~op[0] & a[WIDTH-1];
    assign b_neg_s = ~op[0] & b[WIDTH-1];
    assign div0_s  = op[1] & (b == {WIDTH{1'b0}});
    assign a_mag_s = a_neg_s ? -a : a;
    assign b_mag_s = b_neg_s ? -b : b;

    assign mul_sum_s   = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, div_r} : {(WIDTH+1){1'b0}});
    assign div_shift_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
    assign div_ge_s    = (div_shift_s >= {1'b0, div_r});
    assign div_diff_s  = div_shift_s[WIDTH-1:0] - div_r;

    assign prod_s     = {acc_hi_r, acc_lo_r};
    assign prod_fix_s = neg_q_r ? -prod_s : prod_s;
    assign quo_fix_s  = neg_q_r ? -acc_lo_r : acc_lo_r;
    assign rem_fix_s  = neg_r_r ? -acc_hi_r : acc_hi_r;
    assign res_hi_s   = is_div_r ? rem_fix_s : prod_fix_s[2*WIDTH-1:WIDTH];
    assign res_lo_s   = is_div_r ? quo_fix_s : prod_fix_s[WIDTH-1:0];

    // One shift-add or one restoring-division step.
    always_comb begin
        step_hi_s = acc_hi_r;
        step_lo_s = acc_lo_r;
        if (is_div_r) begin
            step_hi_s = div_ge_s ? div_diff_s : div_shift_s[WIDTH-1:0];
            step_lo_s = {acc_lo_r[WIDTH-2:0], div_ge_s};
        end else begin
            step_hi_s = mul_sum_s[WIDTH:1];
            step_lo_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
        end
    end

    // Sequencer next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    state_s = ST_FIX;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FIX:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture and iteration datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_div_r <= 1'b0;
            div_r    <= {WIDTH{1'b0}};
            acc_hi_r <= {WIDTH{1'b0}};
            acc_lo_r <= {WIDTH{1'b0}};
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        is_div_r <= op[1];
                        div_r    <= op[1] ? b_mag_s : a_mag_s;
                        acc_lo_r <= op[1] ? (div0_s ? a : a_mag_s) : b_mag_s;
                        acc_hi_r <= {WIDTH{1'b0}};
                        neg_q_r  <= ~div0_s & (a_neg_s ^ b_neg_s);
                        neg_r_r  <= ~div0_s & a_neg_s;
                        cnt_r    <= {CNT_W{1'b0}};
                    end
                end
                ST_RUN: begin
                    acc_hi_r <= step_hi_s;
                    acc_lo_r <= step_lo_s;
                    cnt_r    <= cnt_r + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Architectural HI/LO registers and the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= {WIDTH{1'b0}};
            done_r <= 1'b0;
        end else begin
            done_r <= (state_r == ST_FIX);
            if (state_r == ST_FIX) begin
                hi_r <= res_hi_s;
                lo_r <= res_lo_s;
            end else if (state_r == ST_IDLE) begin
                if (hi_write) begin
                    hi_r <= wdata;
                end
                if (lo_write) begin
                    lo_r <= wdata;
                end
            end
        end
    end

    assign hi    = hi_r;
    assign lo    = lo_r;
    assign done  = done_r;
    assign busy  = (state_r != ST_IDLE);
    assign stall = busy & (start | hilo_read | hi_write | lo_write);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: fixed vectors, hand-written corner sequences,
// and random operations checked against an arithmetic reference model.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        hi_write = 1'b0;
    logic        lo_write = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        hilo_read = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[8];

    muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .hi_write  (hi_write),
        .lo_write  (lo_write),
        .wdata     (wdata),
        .hilo_read (hilo_read),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: {hi, lo} from plain arithmetic on the architectural rules.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      p;
        int          q;
        int          r;
        logic [63:0] u;
        case (o)
            2'b00: begin
                p = longint'($signed(x)) * longint'($signed(y));
                return 64'(p);
            end
            2'b01: begin
                u = {32'd0, x} * {32'd0, y};
                return u;
            end
            2'b10: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {r, q};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Issue one op and check busy, latency, the done pulse and the result.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el, input string name);
        logic early;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        check({name, " busy_after_start"}, {63'd0, busy}, 64'd1);
        early = 1'b0;
        for (int k = 1; k < 33; k++) begin
            @(negedge clk);
            if (done || !busy) early = 1'b1;
        end
        check({name, " busy_span"}, {63'd0, early}, 64'd0);
        @(negedge clk);
        check({name, " done"}, {63'd0, done}, 64'd1);
        check({name, " busy_in_done"}, {63'd0, busy}, 64'd0);
        check({name, " hi"}, {32'd0, hi}, {32'd0, eh});
        check({name, " lo"}, {32'd0, lo}, {32'd0, el});
        @(negedge clk);
        check({name, " done_width"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        logic [63:0] exp;
        logic [1:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;
        logic        flag_a;
        logic        flag_b;

        vecs[0] = '{2'b01, 32'd7,          32'd6,          32'd0,          32'd42};
        vecs[1] = '{2'b00, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFF,  32'hFFFF_FFF1};
        vecs[2] = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'h0000_0001};
        vecs[3] = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD};
        vecs[4] = '{2'b11, 32'd100,        32'd7,          32'd2,          32'd14};
        vecs[5] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
        vecs[6] = '{2'b11, 32'h0000_1234,  32'd0,          32'h0000_1234,  32'hFFFF_FFFF};
        vecs[7] = '{2'b10, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  32'hFFFF_FFFF};

        // Reset state
        repeat (3) @(negedge clk);
        hilo_read = 1'b1;
        #1;
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        hilo_read = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));
        end

        // Stall behaviour during an op, then MTLO in the done cycle
        @(negedge clk); hi_write = 1'b1; wdata = 32'h0BAD_0001;
        @(negedge clk); hi_write = 1'b0; lo_write = 1'b1; wdata = 32'h0BAD_0002;
        @(negedge clk); lo_write = 1'b0;
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
        @(negedge clk);
        flag_a = 1'b0;
        flag_b = 1'b0;
        for (int k = 0; k < 33; k++) begin
            start = 1'b1; op = 2'($urandom_range(3, 0)); a = $urandom; b = $urandom;
            hilo_read = 1'b1; hi_write = 1'b1; wdata = $urandom;
            #1;
            if (stall !== 1'b1) flag_a = 1'b1;
            if (hi !== 32'h0BAD_0001 || lo !== 32'h0BAD_0002) flag_b = 1'b1;
            @(negedge clk);
        end
        check("stall while busy", {63'd0, flag_a}, 64'd0);
        check("hilo held while busy", {63'd0, flag_b}, 64'd0);
        start = 1'b0; hi_write = 1'b0; lo_write = 1'b1; wdata = 32'hA5A5_A5A5; hilo_read = 1'b1;
        #1;
        check("stall done cycle", {63'd0, stall}, 64'd0);
        check("done in stall seq", {63'd0, done}, 64'd1);
        check("stall seq hi", {32'd0, hi}, 64'd2);
        check("stall seq lo", {32'd0, lo}, 64'd14);
        @(negedge clk);
        lo_write = 1'b0; hilo_read = 1'b0;
        check("mtlo after done", {32'd0, lo}, {32'd0, 32'hA5A5_A5A5});
        check("hi after mtlo", {32'd0, hi}, 64'd2);
        check("idle after done", {63'd0, busy}, 64'd0);

        // Reset in the middle of an op
        @(negedge clk); hi_write = 1'b1; wdata = 32'h11;
        @(negedge clk); hi_write = 1'b0; lo_write = 1'b1; wdata = 32'h22;
        @(negedge clk); lo_write = 1'b0;
        check("preload hi", {32'd0, hi}, 64'h11);
        check("preload lo", {32'd0, lo}, 64'h22);
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset hi", {32'd0, hi}, 64'd0);
        check("midreset lo", {32'd0, lo}, 64'd0);
        check("midreset busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        flag_a = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) flag_a = 1'b1;
        end
        check("no done after reset", {63'd0, flag_a}, 64'd0);
        run_op(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, "mult after reset");

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(3, 0));
            rx = $urandom;
            if (i % 8 == 0) ry = 32'd0;
            else if (i % 3 == 0) ry = 32'($urandom_range(15, 1));
            else ry = $urandom;
            if (i % 5 == 1) rx = 32'($urandom_range(200, 0));
            exp = model(ro, rx, ry);
            run_op(ro, rx, ry, exp[63:32], exp[31:0], $sformatf("rand%0d op%0d", i, ro));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
